// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: init hold-off, then refresh/write/read bus grant.
// Optional SDRAM_ARBIT_RR_EN: round-robin between write and read.
module sdram_arbit #(
  parameter int ADDR_W = 12,
  parameter int BA_W   = 2,
  parameter int DATA_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              refr_req,
  input  logic              refr_end,
  input  logic [3:0]        refr_cmd,
  input  logic [ADDR_W-1:0] refr_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              refr_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  typedef enum logic [2:0] {
    INIT,
    ARBIT,
    AREF,
    WRITE,
    READ
  } state_t;

  localparam logic [3:0] NOP = 4'b0111;

  state_t     state;
  logic       wr_go;
  logic       rd_go;
  logic [3:0] cmd;

`ifdef SDRAM_ARBIT_RR_EN
  // last_grant: 0 = write, 1 = read
  logic last_grant;

  assign wr_go = wr_req && (!rd_req || last_grant);
  assign rd_go = rd_req && !wr_go;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_grant <= 1'b1;
    end else if (state == ARBIT && !refr_req) begin
      if (wr_go)
        last_grant <= 1'b0;
      else if (rd_go)
        last_grant <= 1'b1;
    end
  end
`else
  assign wr_go = wr_req;
  assign rd_go = rd_req && !wr_req;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= INIT;
    end else begin
      case (state)
        INIT:
          if (init_end) state <= ARBIT;
        ARBIT:
          if (refr_req)   state <= AREF;
          else if (wr_go) state <= WRITE;
          else if (rd_go) state <= READ;
        AREF:
          if (refr_end) state <= ARBIT;
        WRITE:
          if (wr_end) state <= ARBIT;
        READ:
          if (rd_end) state <= ARBIT;
        default:
          state <= INIT;
      endcase
    end
  end

  assign refr_en   = (state == AREF);
  assign wr_en     = (state == WRITE);
  assign rd_en     = (state == READ);
  assign sdram_cke = 1'b1;

  // Reset forces NOP on the pins even though INIT would pass init_cmd.
  always_comb begin
    cmd        = NOP;
    sdram_ba   = '0;
    sdram_addr = '0;
    if (sys_rst_n) begin
      case (state)
        INIT: begin
          cmd        = init_cmd;
          sdram_ba   = init_ba;
          sdram_addr = init_addr;
        end
        AREF: begin
          cmd        = refr_cmd;
          sdram_addr = refr_addr;
        end
        WRITE: begin
          cmd        = wr_cmd;
          sdram_ba   = wr_ba;
          sdram_addr = wr_addr;
        end
        READ: begin
          cmd        = rd_cmd;
          sdram_ba   = rd_ba;
          sdram_addr = rd_addr;
        end
        default: begin
          cmd        = NOP;
          sdram_ba   = '0;
          sdram_addr = '0;
        end
      endcase
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sdram_dq_out <= '0;
      sdram_dq_oe  <= 1'b0;
    end else begin
      sdram_dq_out <= wr_data;
      sdram_dq_oe  <= (state == WRITE) && wr_sdram_en;
    end
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: init, priority, DQ gating, reset, fairness.
// Compile with +define+SDRAM_ARBIT_RR_EN to exercise round-robin.
module tb_sdram_arbit;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        init_end;
  logic [3:0]  init_cmd;
  logic [1:0]  init_ba;
  logic [11:0] init_addr;
  logic        refr_req, refr_end;
  logic [3:0]  refr_cmd;
  logic [11:0] refr_addr;
  logic        wr_req, wr_end;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_ba;
  logic [11:0] wr_addr;
  logic        wr_sdram_en;
  logic [15:0] wr_data;
  logic        rd_req, rd_end;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [11:0] rd_addr;
  logic        refr_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;

  int tests = 0;
  int fails = 0;

  always #10 sys_clk = ~sys_clk;

  sdram_arbit dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .init_end(init_end), .init_cmd(init_cmd),
    .init_ba(init_ba), .init_addr(init_addr),
    .refr_req(refr_req), .refr_end(refr_end),
    .refr_cmd(refr_cmd), .refr_addr(refr_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd),
    .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_sdram_en(wr_sdram_en), .wr_data(wr_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd),
    .rd_ba(rd_ba), .rd_addr(rd_addr),
    .refr_en(refr_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  wire [3:0] pcmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  wire [2:0] gnt  = {refr_en, wr_en, rd_en};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  logic [2:0] seen [4];
  logic [2:0] want [4];

  initial begin
    sys_rst_n = 1'b0; init_end = 1'b0;
    init_cmd = 4'b0010; init_ba = 2'd1; init_addr = 12'h400;
    refr_req = 0; refr_end = 0; refr_cmd = 4'b0001; refr_addr = 12'h123;
    wr_req = 0; wr_end = 0; wr_cmd = 4'b0100; wr_ba = 2'd2;
    wr_addr = 12'h055; wr_sdram_en = 0; wr_data = 16'h0000;
    rd_req = 0; rd_end = 0; rd_cmd = 4'b0101; rd_ba = 2'd3;
    rd_addr = 12'h0AA;
    #35;
    chk("rst_cmd", pcmd, 4'b0111);
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_oe", sdram_dq_oe, 1'b0);
    chk("rst_dq", sdram_dq_out, 16'h0000);
    chk("rst_cke", sdram_cke, 1'b1);
    sys_rst_n = 1'b1;
    repeat (20) tick();
    chk("init_cmd", pcmd, 4'b0010);
    chk("init_ba", sdram_ba, 2'd1);
    chk("init_addr", sdram_addr, 12'h400);
    chk("init_gnt", gnt, 3'b000);

    init_end = 1'b1;
    tick();
    chk("arb_cmd", pcmd, 4'b0111);
    chk("arb_addr", sdram_addr, 12'h000);

    refr_req = 1; wr_req = 1;
    tick();
    chk("pri_gnt", gnt, 3'b100);
    chk("aref_cmd", pcmd, 4'b0001);
    chk("aref_ba", sdram_ba, 2'd0);
    chk("aref_addr", sdram_addr, 12'h123);
    refr_end = 1; refr_req = 0;
    tick();
    chk("aref_done", gnt, 3'b000);
    refr_end = 0;
    tick();
    chk("wr_gnt", gnt, 3'b010);

    wr_req = 0; wr_sdram_en = 1; wr_data = 16'hA5A5;
    #1;
    chk("wr_cmd", pcmd, 4'b0100);
    chk("wr_ba", sdram_ba, 2'd2);
    chk("wr_addr", sdram_addr, 12'h055);
    chk("wr_oe0", sdram_dq_oe, 1'b0);
    tick();
    chk("wr_oe1", sdram_dq_oe, 1'b1);
    chk("wr_dq", sdram_dq_out, 16'hA5A5);
    wr_end = 1;
    tick();
    chk("wr_done", gnt, 3'b000);
    wr_end = 0; wr_sdram_en = 0;
    tick();
    chk("wr_oe_off", sdram_dq_oe, 1'b0);

    rd_req = 1;
    tick();
    chk("rd_gnt", gnt, 3'b001);
    chk("rd_cmd", pcmd, 4'b0101);
    chk("rd_addr", sdram_addr, 12'h0AA);
    rd_req = 0; refr_req = 1;
    tick();
    chk("rd_hold1", gnt, 3'b001);
    tick();
    chk("rd_hold2", gnt, 3'b001);
    rd_end = 1;
    tick();
    chk("rd_done", gnt, 3'b000);
    rd_end = 0;
    tick();
    chk("aref_after", gnt, 3'b100);
    wr_end = 1;
    tick();
    chk("stray_end", gnt, 3'b100);
    wr_end = 0; refr_end = 1; refr_req = 0;
    tick();
    refr_end = 0; init_end = 0;
    tick();
    chk("init_fall", pcmd, 4'b0111);
    chk("init_fall_g", gnt, 3'b000);

    wr_req = 1; wr_sdram_en = 1; wr_data = 16'h3C3C;
    tick();
    tick();
    chk("pre_rst_oe", sdram_dq_oe, 1'b1);
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_cmd", pcmd, 4'b0111);
    chk("arst_gnt", gnt, 3'b000);
    chk("arst_oe", sdram_dq_oe, 1'b0);
    wr_req = 0; wr_sdram_en = 0;
    #5;
    sys_rst_n = 1'b1;
    tick();
    chk("reinit_cmd", pcmd, 4'b0010);
    chk("reinit_gnt", gnt, 3'b000);

    init_end = 1;
    tick();
    wr_req = 1; rd_req = 1;
`ifdef SDRAM_ARBIT_RR_EN
    want[0] = 3'b010; want[1] = 3'b001;
    want[2] = 3'b010; want[3] = 3'b001;
`else
    want[0] = 3'b010; want[1] = 3'b010;
    want[2] = 3'b010; want[3] = 3'b010;
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      seen[i] = gnt;
      wr_end = 1; rd_end = 1;
      tick();
      wr_end = 0; rd_end = 0;
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("burst%0d", i), seen[i], want[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
Central SDRAM command arbiter. Holds the controller in initialisation until power-up completes, then grants the SDRAM command bus to one of three requesters: auto-refresh, write or read. It drives the selected requester's command, bank and address onto the SDRAM pins, and gates the DQ output driver. It sits between the init, auto-refresh, write and read engines and the SDRAM pads.

Parameters:
ADDR_W, 12, SDRAM row/column address width
BA_W, 2, bank address width
DATA_W, 16, DQ width

Ports:
sys_clk  in  1  system clock (50 MHz)
sys_rst_n  in  1  async active-low reset
init_end  in  1  init sequence finished (level, stays high)
init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
init_ba  in  BA_W  init bank
init_addr  in  ADDR_W  init address
refr_req  in  1  refresh request (level, held until serviced)
refr_end  in  1  refresh burst complete
refr_cmd  in  4  refresh command
refr_addr  in  ADDR_W  refresh address
wr_req  in  1  write request
wr_end  in  1  write burst complete
wr_cmd  in  4  write command
wr_ba  in  BA_W  write bank
wr_addr  in  ADDR_W  write address
wr_sdram_en  in  1  write engine drives DQ
wr_data  in  DATA_W  write data
rd_req  in  1  read request
rd_end  in  1  read burst complete
rd_cmd  in  4  read command
rd_ba  in  BA_W  read bank
rd_addr  in  ADDR_W  read address
refr_en  out  1  refresh grant
wr_en  out  1  write grant
rd_en  out  1  read grant
sdram_cke  out  1  clock enable
sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
sdram_ba  out  BA_W  bank pins
sdram_addr  out  ADDR_W  address pins
sdram_dq_out  out  DATA_W  DQ output data
sdram_dq_oe  out  1  DQ output enable

Behaviour:
- Reset is sys_rst_n, asynchronous, active-low; clock is sys_clk.
- States (registered): INIT, ARBIT, AREF, WRITE, READ. Reset state is INIT.
- Reset values: all grants 0; sdram_cke 1; command NOP (4'b0111); ba 0; addr 0; dq_oe 0; dq_out 0.
- INIT -> ARBIT when init_end=1.
- ARBIT applies fixed priority refr_req > wr_req > rd_req, evaluated on one edge: go to AREF, WRITE or READ respectively. Otherwise stay.
- AREF -> ARBIT when refr_end=1. WRITE -> ARBIT when wr_end=1. READ -> ARBIT when rd_end=1.
- No preemption: a request arriving mid-burst waits. A pending refr_req wins at the next ARBIT cycle.
- Grants are combinational state decodes: refr_en=(state==AREF), wr_en=(state==WRITE), rd_en=(state==READ). Grants are mutually exclusive and deassert the cycle after the end pulse is sampled.
- Command/ba/addr mux by state: INIT uses the init_* inputs. AREF uses refr_cmd/refr_addr with ba=0. WRITE uses the wr_* inputs. READ uses the rd_* inputs. ARBIT drives NOP, ba=0, addr=0.
- Pin outputs are combinational from the registered state and requester outputs, so they add zero latency.
- sdram_dq_out registers wr_data. sdram_dq_oe registers (state==WRITE && wr_sdram_en). Both have 1-cycle latency, aligned to the write engine's registered command.
- An end pulse received in a non-matching state is ignored.
- init_end falling after INIT is ignored; INIT is re-entered only via reset.
- Reset mid-burst: immediate return to INIT with NOP, all grants low and oe low.
- Minimum ARBIT dwell is 1 cycle between consecutive bursts.

Optional Feature:
SDRAM_ARBIT_RR_EN: when defined, write and read arbitration is round-robin. A 1-bit last_grant register (reset = read) is updated on each WRITE/READ entry. When wr_req and rd_req are both high in ARBIT, the requester not granted last wins. Refresh keeps absolute priority. When not defined, fixed wr > rd priority applies and no last_grant register exists.

Test Plan:
- Reset, hold init_end=0 for 20 cycles, drive init_cmd=4'b0010 -> pins show 0010, all grants 0. Raise init_end -> state ARBIT next edge, pins NOP.
- In ARBIT, raise refr_req and wr_req on the same edge -> refr_en=1 next cycle, wr_en=0. Pulse refr_end -> refr_en=0 next cycle, then wr_en=1 one cycle later.
- WRITE granted, wr_sdram_en=1, wr_data=16'hA5A5 -> dq_oe=1 and dq_out=A5A5 one cycle later. wr_end -> dq_oe=0 within 2 cycles.
- READ granted, refr_req rises mid-burst -> rd_en stays 1 until rd_end, then refr_en asserts after one ARBIT cycle.
- Assert sys_rst_n=0 during WRITE -> pins NOP, wr_en=0 and dq_oe=0 asynchronously. Release -> INIT.
- With SDRAM_ARBIT_RR_EN, hold wr_req=rd_req=1 across four bursts -> grants alternate W,R,W,R. Without it -> all four are W.
